// File: rtl/ntt_pkg.sv
// Shared definitions for the 512-point mixed-radix NTT sequencer.
// Contents: size constants, the sequencer state encoding, the delay-line
// entry layout and the (p, c) -> tuple / address-group mapping that the
// read-side address generator reuses.
package ntt_pkg;

  localparam int N         = 512;
  localparam int ADDR_W    = $clog2(N);
  localparam int STAGE_CYC = 128;
  localparam int CNT_W     = $clog2(STAGE_CYC);

  localparam logic [2:0] FIRST_P = 3'd4;
  localparam logic [2:0] LAST_P  = 3'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Four butterfly addresses, element m is a_m.
  typedef logic [3:0][ADDR_W-1:0] addr_group_t;

  typedef struct packed {
    logic [CNT_W-1:0] i;
    logic [CNT_W-1:0] k;
    logic [CNT_W-1:0] j;
  } tuple_t;

  typedef struct packed {
    logic        valid;
    addr_group_t addr;
    logic [2:0]  p;
  } dl_entry_t;

  // Radix-2 pass uses i=c; radix-4 passes split c into group k and offset j
  // with j taking the low 2p bits.
  function automatic tuple_t ntt_tuple(input logic [2:0] p, input logic [CNT_W-1:0] c);
    tuple_t           t;
    logic [3:0]       sh;
    logic [CNT_W-1:0] mask;
    t    = '0;
    sh   = {p, 1'b0};
    mask = (CNT_W'(1) << sh) - CNT_W'(1);
    if (p == FIRST_P) begin
      t.i = c;
    end else begin
      t.j = c & mask;
      t.k = c >> sh;
    end
    return t;
  endfunction

  // a0 = k*4^(p+1) + j and stride 4^p for radix-4; a0 = i, stride 128 for
  // the radix-2 pass. All results stay below N by construction.
  function automatic addr_group_t ntt_addr_group(input logic [2:0] p, input logic [CNT_W-1:0] c);
    addr_group_t       g;
    tuple_t            t;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] step;
    logic [3:0]        sh;
    t  = ntt_tuple(p, c);
    sh = {p, 1'b0};
    if (p == FIRST_P) begin
      base = ADDR_W'(t.i);
      step = ADDR_W'(STAGE_CYC);
    end else begin
      base = (ADDR_W'(t.k) << (sh + 4'd2)) + ADDR_W'(t.j);
      step = ADDR_W'(1) << sh;
    end
    g[0] = base;
    g[1] = base + step;
    g[2] = base + {step[ADDR_W-2:0], 1'b0};
    g[3] = base + step + {step[ADDR_W-2:0], 1'b0};
    return g;
  endfunction

endpackage

// File: rtl/ntt_wb_sequencer_if.sv
// Control/issue/write-back bundle of the NTT sequencer.
//   start, stall            : control into the sequencer
//   iss_valid, iss_p/i/k/j  : read-side tuple
//   wr_en, wr_addr_0..3,wr_p: write-port address group
//   busy, done              : status
// master = sequencer side, slave = controller / memory side.
interface ntt_wb_sequencer_if;
  import ntt_pkg::*;

  logic              start;
  logic              stall;
  logic              iss_valid;
  logic [2:0]        iss_p;
  logic [CNT_W-1:0]  iss_i;
  logic [CNT_W-1:0]  iss_k;
  logic [CNT_W-1:0]  iss_j;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr_0;
  logic [ADDR_W-1:0] wr_addr_1;
  logic [ADDR_W-1:0] wr_addr_2;
  logic [ADDR_W-1:0] wr_addr_3;
  logic [2:0]        wr_p;
  logic              busy;
  logic              done;

  modport master (
    input  start, stall,
    output iss_valid, iss_p, iss_i, iss_k, iss_j,
    output wr_en, wr_addr_0, wr_addr_1, wr_addr_2, wr_addr_3, wr_p,
    output busy, done
  );

  modport slave (
    output start, stall,
    input  iss_valid, iss_p, iss_i, iss_k, iss_j,
    input  wr_en, wr_addr_0, wr_addr_1, wr_addr_2, wr_addr_3, wr_p,
    input  busy, done
  );

endinterface

// File: rtl/ntt_wb_delay_line.sv
// Enable-gated shift register that carries each issued address group
// through the butterfly latency.
//   clk, rst_n : clock, async active-low clear
//   en         : shift enable (pipeline advance)
//   din        : entry pushed at stage 0 (valid=0 is a bubble)
//   tail       : oldest stage, i.e. the entry at the write port
//   empty      : no valid entry behind the tail, so the line is empty as
//                soon as the current shift completes
module ntt_wb_delay_line
  import ntt_pkg::*;
#(
  parameter int LATENCY = 6
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en,
  input  dl_entry_t din,
  output dl_entry_t tail,
  output logic      empty
);

  dl_entry_t stage [LATENCY];

  // Shift register body; holds completely while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else if (en) begin
      stage[0] <= din;
      for (int i = 1; i < LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // Look-ahead empty: the tail leaves on the next shift, so only the
  // stages behind it matter. This lets the next stage issue on the cycle
  // right after the last write.
  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < LATENCY - 1; i++) begin
      empty = empty & ~stage[i].valid;
    end
  end

  assign tail = stage[LATENCY-1];

endmodule

// File: rtl/ntt_wb_sequencer.sv
// Loop controller and write-back address source for the 512-point
// mixed-radix NTT (radix-2 pass p=4, then radix-4 passes p=3..0).
//   clk, rst_n : clock, async active-low reset
//   bus        : ntt_wb_sequencer_if master (start/stall in; issue tuple,
//                write group, busy and done out)
// Each stage issues 128 tuples, then drains the butterfly pipeline so the
// next in-place read never overtakes a pending write.
module ntt_wb_sequencer
  import ntt_pkg::*;
#(
  parameter int LATENCY = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  ntt_wb_sequencer_if.master  bus
);

  state_t           state;
  logic [CNT_W-1:0] c;
  logic [2:0]       p;
  logic             iss_valid;
  logic [CNT_W-1:0] iss_i;
  logic [CNT_W-1:0] iss_k;
  logic [CNT_W-1:0] iss_j;
  logic             busy;
  logic             done;

  logic             adv;
  tuple_t           nxt;
  dl_entry_t        dl_in;
  dl_entry_t        tail;
  logic             drained;

  // Advance qualifier, next-tuple lookup and the entry for the delay line.
  always_comb begin
    adv         = ~bus.stall;
    nxt         = ntt_tuple(p, c + CNT_W'(1));
    dl_in.valid = (state == S_ISSUE);
    dl_in.addr  = ntt_addr_group(p, c);
    dl_in.p     = p;
  end

  // Sequencing FSM: state, stage, counter and registered issue/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      c         <= '0;
      p         <= FIRST_P;
      iss_valid <= 1'b0;
      iss_i     <= '0;
      iss_k     <= '0;
      iss_j     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // start is honoured even while stalled
          if (bus.start) begin
            state     <= S_ISSUE;
            p         <= FIRST_P;
            c         <= '0;
            iss_valid <= 1'b1;
            iss_i     <= '0;
            iss_k     <= '0;
            iss_j     <= '0;
            busy      <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (adv) begin
            if (c == CNT_W'(STAGE_CYC - 1)) begin
              state     <= S_DRAIN;
              c         <= '0;
              iss_valid <= 1'b0;
            end else begin
              c     <= c + CNT_W'(1);
              iss_i <= nxt.i;
              iss_k <= nxt.k;
              iss_j <= nxt.j;
            end
          end
        end
        S_DRAIN: begin
          if (adv && drained) begin
            if (p == LAST_P) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              // tuple for c=0 is all-zero in every stage
              state     <= S_ISSUE;
              p         <= p - 3'd1;
              c         <= '0;
              iss_valid <= 1'b1;
              iss_i     <= '0;
              iss_k     <= '0;
              iss_j     <= '0;
            end
          end
        end
        S_DONE: begin
          if (adv) begin
            state <= S_IDLE;
            done  <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          iss_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  ntt_wb_delay_line #(
    .LATENCY(LATENCY)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .din   (dl_in),
    .tail  (tail),
    .empty (drained)
  );

  assign bus.iss_valid = iss_valid;
  assign bus.iss_p     = p;
  assign bus.iss_i     = iss_i;
  assign bus.iss_k     = iss_k;
  assign bus.iss_j     = iss_j;
  assign bus.busy      = busy;
  assign bus.done      = done;

  // The write strobe drops with stall so a held tail is never written twice.
  assign bus.wr_en     = tail.valid & adv;
  assign bus.wr_addr_0 = tail.addr[0];
  assign bus.wr_addr_1 = tail.addr[1];
  assign bus.wr_addr_2 = tail.addr[2];
  assign bus.wr_addr_3 = tail.addr[3];
  assign bus.wr_p      = tail.p;

endmodule

// File: tb/tb_ntt_wb_sequencer.sv
// Scoreboard bench for ntt_wb_sequencer (LATENCY=6): stimulus pushes the
// expected tuples, write groups (with their cycle) and done cycle; a
// negedge monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_ntt_wb_sequencer;

  localparam int L         = 6;
  localparam int STAGE_LEN = 128 + L;
  localparam int BIG       = 1000000;

  typedef struct {
    logic [38:0] grp;
    int          cyc;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ntt_wb_sequencer_if bus();

  ntt_wb_sequencer #(.LATENCY(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  wr_exp_t     wq[$];
  logic [23:0] iq[$];
  int          dq[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  int          t0         = 0;
  int          nwr        = 0;
  int          seen [0:4][0:511];
  wr_exp_t     mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at rel cycle %0d",
               name, act, act, exp, exp, cyc - t0);
    end
  endtask

  task automatic unexpected(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: DUT output with nothing expected at rel cycle %0d", name, cyc - t0);
  endtask

  // Reference mapping written arithmetically: 4^p stride, divide/modulo split.
  function automatic logic [38:0] model_grp(input int p, input int c);
    int a0, step;
    if (p == 4) begin
      a0   = c;
      step = 128;
    end else begin
      step = 4 ** p;
      a0   = (c / step) * step * 4 + (c % step);
    end
    return {9'(a0 + 3 * step), 9'(a0 + 2 * step), 9'(a0 + step), 9'(a0), 3'(p)};
  endfunction

  function automatic logic [23:0] model_tuple(input int p, input int c);
    int i, k, j;
    i = 0; k = 0; j = 0;
    if (p == 4) i = c;
    else begin
      j = c % (4 ** p);
      k = c / (4 ** p);
    end
    return {3'(p), 7'(i), 7'(k), 7'(j)};
  endfunction

  task automatic push_run(input int stall_at, input int stall_len, input int cut);
    int p, ic, wc, dc;
    wr_exp_t e;
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 128; c++) begin
        p  = 4 - s;
        ic = 1 + s * STAGE_LEN + c;
        wc = ic + L;
        if (stall_at > 0 && wc >= stall_at) wc = wc + stall_len;
        if (ic < cut) iq.push_back(model_tuple(p, c));
        if (wc < cut) begin
          e.grp = model_grp(p, c);
          e.cyc = wc;
          wq.push_back(e);
        end
      end
    end
    dc = 1 + 5 * STAGE_LEN + ((stall_at > 0) ? stall_len : 0);
    if (dc < cut) dq.push_back(dc);
  endtask

  task automatic new_run();
    wq.delete(); iq.delete(); dq.delete();
    nwr = 0;
    for (int s = 0; s < 5; s++)
      for (int a = 0; a < 512; a++) seen[s][a] = 0;
  endtask

  task automatic end_run(input string tag, input int exp_wr);
    check({tag, "_wq_left"}, wq.size(), 0);
    check({tag, "_iq_left"}, iq.size(), 0);
    check({tag, "_dq_left"}, dq.size(), 0);
    check({tag, "_wr_count"}, nwr, exp_wr);
  endtask

  task automatic check_cover(input string tag);
    int cnt;
    for (int s = 0; s < 5; s++) begin
      cnt = 0;
      for (int a = 0; a < 512; a++) if (seen[s][a] == 1) cnt++;
      check($sformatf("%s_cover_p%0d", tag, 4 - s), cnt, 512);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    t0 = cyc - 1;
  endtask

  task automatic at_rel(input int n);
    while (cyc - t0 < n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"}, {bus.iss_valid, bus.wr_en, bus.busy, bus.done}, 4'b0000);
    check({tag, "_iss"}, {bus.iss_p, bus.iss_i, bus.iss_k, bus.iss_j}, {3'd4, 21'd0});
    check({tag, "_wr"}, {bus.wr_addr_3, bus.wr_addr_2, bus.wr_addr_1, bus.wr_addr_0, bus.wr_p}, 39'd0);
  endtask

  // Monitor: pops scoreboard entries whenever the DUT presents an output.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.wr_en === 1'b1) begin
        nwr++;
        if (bus.wr_p <= 3'd4) begin
          seen[4 - int'(bus.wr_p)][bus.wr_addr_0]++;
          seen[4 - int'(bus.wr_p)][bus.wr_addr_1]++;
          seen[4 - int'(bus.wr_p)][bus.wr_addr_2]++;
          seen[4 - int'(bus.wr_p)][bus.wr_addr_3]++;
        end
        if (wq.size() == 0) unexpected("wr_extra");
        else begin
          mon_e = wq.pop_front();
          check("wr_group", {bus.wr_addr_3, bus.wr_addr_2, bus.wr_addr_1, bus.wr_addr_0, bus.wr_p}, mon_e.grp);
          check("wr_cycle", cyc - t0, mon_e.cyc);
        end
      end
      if (bus.iss_valid === 1'b1 && bus.stall === 1'b0) begin
        if (iq.size() == 0) unexpected("iss_extra");
        else check("iss_tuple", {bus.iss_p, bus.iss_i, bus.iss_k, bus.iss_j}, iq.pop_front());
      end
      if (bus.done === 1'b1) begin
        if (dq.size() == 0) unexpected("done_extra");
        else check("done_cycle", cyc - t0, dq.pop_front());
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Run A: clean run with directed timing points and a start while busy.
    new_run();
    push_run(0, 0, BIG);
    do_start();
    at_rel(1);
    check("a_iss_first", {bus.iss_valid, bus.iss_p, bus.iss_i, bus.busy}, {1'b1, 3'd4, 7'd0, 1'b1});
    at_rel(7);
    check("a_wr_first", {bus.wr_en, bus.wr_addr_3, bus.wr_addr_2, bus.wr_addr_1, bus.wr_addr_0, bus.wr_p},
          {1'b1, 9'd384, 9'd256, 9'd128, 9'd0, 3'd4});
    at_rel(134);
    check("a_p4_last_wr", {bus.wr_en, bus.iss_valid, bus.wr_p}, {1'b1, 1'b0, 3'd4});
    at_rel(135);
    check("a_p3_issue", {bus.iss_valid, bus.iss_p, bus.wr_en}, {1'b1, 3'd3, 1'b0});
    at_rel(299);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    at_rel(408);
    check("a_s1_c5_iss", {bus.iss_valid, bus.iss_p, bus.iss_k, bus.iss_j}, {1'b1, 3'd1, 7'd1, 7'd1});
    at_rel(414);
    check("a_s1_c5_wr", {bus.wr_en, bus.wr_addr_3, bus.wr_addr_2, bus.wr_addr_1, bus.wr_addr_0, bus.wr_p},
          {1'b1, 9'd29, 9'd25, 9'd21, 9'd17, 3'd1});
    at_rel(671);
    check("a_done_pulse", {bus.done, bus.busy}, 2'b11);
    at_rel(672);
    check("a_after_done", {bus.done, bus.busy}, 2'b00);
    at_rel(676);
    end_run("a", 640);
    check_cover("a");

    // Run B: 10-cycle stall while p=3 issues c=40.
    new_run();
    push_run(175, 10, BIG);
    do_start();
    at_rel(174);
    @(posedge clk);
    #1 bus.stall = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("b_stall_hold",
            {bus.iss_valid, bus.iss_p, bus.iss_k, bus.iss_j, bus.wr_en,
             bus.wr_addr_3, bus.wr_addr_2, bus.wr_addr_1, bus.wr_addr_0, bus.wr_p},
            {1'b1, 3'd3, 7'd0, 7'd40, 1'b0, 9'd226, 9'd162, 9'd98, 9'd34, 3'd3});
      @(posedge clk);
    end
    #1 bus.stall = 1'b0;
    at_rel(681);
    check("b_done_late", {bus.done, bus.busy}, 2'b11);
    at_rel(686);
    end_run("b", 640);
    check_cover("b");

    // Run C: reset during the p=2 drain.
    new_run();
    push_run(0, 0, 399);
    do_start();
    at_rel(398);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("c_abort");
    end_run("c", 380);
    new_run();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("c_idle", {bus.busy, bus.iss_valid, bus.wr_en, bus.done}, 4'b0000);

    // Run D: restart after the abort begins again at p=4, c=0.
    new_run();
    push_run(0, 0, BIG);
    do_start();
    at_rel(1);
    check("d_iss_first", {bus.iss_valid, bus.iss_p, bus.iss_i, bus.iss_k, bus.iss_j},
          {1'b1, 3'd4, 21'd0});
    at_rel(7);
    check("d_wr_first", {bus.wr_en, bus.wr_addr_3, bus.wr_addr_2, bus.wr_addr_1, bus.wr_addr_0, bus.wr_p},
          {1'b1, 9'd384, 9'd256, 9'd128, 9'd0, 3'd4});
    at_rel(676);
    end_run("d", 640);
    check_cover("d");
    check("d_idle", {bus.busy, bus.done}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ntt_wb_sequencer.md
Name: ntt_wb_sequencer

Overview:
- Loop controller and write-back address source for the 512-point mixed-radix NTT (one radix-2 pass p=4, then radix-4 passes p=3..0).
- Drives the read-side address generator with (p, i, k, j) tuples, one per cycle.
- Delays the matching 4-address group by the butterfly pipeline depth, so wr_en and wr_addr_0..3 line up with butterfly results at the memory write port.
- Between stages it drains the pipeline so in-place reads never overtake pending writes.

Parameters:
- LATENCY, 6, butterfly pipeline depth in advancing cycles from iss_valid to wr_en; legal 1..16.
- STAGE_CYC, 128, butterfly groups per stage; fixed for N=512.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- stall  in  1  global hold; freezes the counter, stage and delay line
- iss_valid  out  1  iss_* tuple valid for the read side
- iss_p  out  3  stage index to the read generator
- iss_i  out  7  radix-2 index (p=4), else 0
- iss_k  out  7  radix-4 group index, else 0
- iss_j  out  7  radix-4 in-group offset, else 0
- wr_en  out  1  write strobe for the four result words
- wr_addr_0..wr_addr_3  out  9 each  write addresses
- wr_p  out  3  stage tag of the write group
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low. The flop-clear edge is the async reset; all other updates are on the rising clk edge.
- Reset values:
  - iss_valid=0, wr_en=0, busy=0, done=0.
  - iss_p=4, iss_i/k/j=0, wr_addr_*=0, wr_p=0.
  - Delay-line valid bits cleared; state=IDLE; counter c=0.
- Reset asserted mid-operation aborts immediately. No further wr_en occurs.
- adv = !stall. Every state change, counter step and delay-line shift happens only when adv=1.
- States: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: on start (stall ignored), go to ISSUE with p=4, c=0. start is ignored in all other states.
  - ISSUE: iss_valid=1, including while stalled, with the tuple held. On adv:
    - push {valid, addr group, p} into the delay line;
    - if c==127, go to DRAIN with c=0; else c=c+1.
  - DRAIN: iss_valid=0; bubbles are shifted in. When the delay line is empty:
    - if p==0, go to DONE;
    - else go to ISSUE with the next p in the order 4→3→2→1→0.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in ISSUE, DRAIN and DONE.
- Tuple mapping from c:
  - p=4: i=c, k=j=0.
  - p<4: j=c mod 4^p, k=c>>(2p), i=0.
- Address group, 9-bit, never exceeds 511:
  - p<4: a0=k·4^(p+1)+j, a_m=a0+m·4^p.
  - p=4: a0=i, a_m=i+m·128.
- wr_en = tail valid & adv. wr_addr_*/wr_p show the tail entry and are held while stalled.
- Timing without stalls:
  - ISSUE entered at t0 → tuple c is issued at t0+c, and its write happens at t0+c+LATENCY.
  - Next ISSUE starts at t0+128+LATENCY.
  - Total run: 5·(128+LATENCY) cycles, then the done cycle.
- Stall applied during DRAIN extends the drain cycle-for-cycle. Draining is never skipped.

Decomposition:
- Package ntt_pkg holds:
  - constants N=512, ADDR_W=9, STAGE_CYC=128, FIRST_P=4, LAST_P=0;
  - state enum;
  - pure function ntt_addr_group(p,c) returning the four 9-bit addresses, shared with the read side.
- Sub-module ntt_wb_delay_line: LATENCY-deep, enable-gated shift register of {valid, 4×9 addr, 3-bit p}, with async clear and an empty flag.

Test Plan:
- Reset then start, stall=0, LATENCY=6:
  - iss_valid from cycle 1 with p=4, i=0;
  - first wr_en at cycle 7 with addrs 0,128,256,384, wr_p=4;
  - 128 consecutive wr_en, then 0 for 0 cycles before the p=3 issue; ISSUE(p=3) at cycle 135.
- Stage 1, c=5:
  - iss k=1, j=1;
  - wr addrs 17,21,25,29, wr_p=1.
- Full run:
  - exactly 640 wr_en, in 5 stages of 128;
  - every address 0..511 written once per stage;
  - done pulses once at cycle 5·134+1=671; busy low afterwards.
- stall=1 for 10 cycles mid-ISSUE (p=3, c=40):
  - iss tuple frozen at k=0, j=40;
  - wr_en=0 during the stall, with outputs held;
  - final done delayed by exactly 10 cycles.
- rst_n pulled low in DRAIN of p=2:
  - all outputs return to reset values immediately, no wr_en;
  - a new start restarts at p=4, c=0.
- start pulsed while busy: no effect on counter, stage or done timing.
